// File: rtl/mem_line_responder.sv
// mem_line_responder: line-granular backing memory behind a cache fill/write-back
// port. Requests queue in a small circular FIFO and are served strictly in
// order. Each one takes LATENCY cycles, and its response is held until the
// cache acknowledges it.
module mem_line_responder #(
  parameter int N_ELEMENTS  = 2,
  parameter int N_BYTES     = 4,
  parameter int PA_WIDTH    = 8,
  parameter int LATENCY     = 4,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                i_mem_enable,
  input  logic                                i_mem_type,
  input  logic [PA_WIDTH-1:0]                 i_mem_addr,
  input  logic [N_ELEMENTS*N_BYTES*8-1:0]     i_mem_data,
  output logic                                o_full,
  output logic                                o_busy,
  output logic                                o_resp_valid,
  output logic                                o_resp_type,
  output logic [PA_WIDTH-1:0]                 o_resp_addr,
  output logic [N_ELEMENTS*N_BYTES*8-1:0]     o_resp_data,
  input  logic                                i_resp_ack,
  output logic                                o_overflow
);

  localparam int LINE_WIDTH  = N_ELEMENTS * N_BYTES * 8;
  localparam int OFF_W       = $clog2(N_ELEMENTS * N_BYTES);
  localparam int IDX_W       = PA_WIDTH - OFF_W;
  localparam int N_MEM_LINES = 2 ** IDX_W;
  localparam int PTR_W       = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int QCNT_W      = $clog2(QUEUE_DEPTH + 1);
  localparam int CNT_W       = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_t;

  // A queued request keeps only the line index; the offset is never needed again.
  typedef struct packed {
    logic                  typ;
    logic [IDX_W-1:0]      idx;
    logic [LINE_WIDTH-1:0] data;
  } req_t;

  logic [LINE_WIDTH-1:0] mem [N_MEM_LINES];
  req_t                  fifo [QUEUE_DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [QCNT_W-1:0]     count;
  state_t                state;
  logic [CNT_W-1:0]      cnt;
  req_t                  work;
  logic                  push;
  logic                  pop;
  logic                  mem_we;
  req_t                  in_req;

  // The byte-offset bits are dropped on purpose: all access is whole-line.
  logic unused_offset;
  assign unused_offset = ^i_mem_addr[OFF_W-1:0];

  assign in_req = '{typ: i_mem_type, idx: i_mem_addr[PA_WIDTH-1:OFF_W], data: i_mem_data};

  assign o_full = (count == QCNT_W'(QUEUE_DEPTH));
  assign o_busy = (state != S_IDLE) || (count != '0);
  assign push   = i_mem_enable && !o_full;
  assign pop    = (state == S_IDLE) && (count != '0);
  assign mem_we = (state == S_BUSY) && (cnt == '0) && work.typ;

  // FIFO payload storage: written on push only.
  // NOTE: no reset on the payload slots; count and the pointers decide which are valid.
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= in_req;
  end

  // FIFO pointers and occupancy; a full FIFO rejects even when a pop frees a slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + QCNT_W'(1);
        2'b01:   count <= count - QCNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky flag recording any request dropped because the FIFO was full.
  always_ff @(posedge clk) begin
    if (rst) o_overflow <= 1'b0;
    else if (i_mem_enable && o_full) o_overflow <= 1'b1;
  end

  // Line array: cleared on reset so untouched lines read back as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_MEM_LINES; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[work.idx] <= work.data;
    end
  end

  // Service FSM: pop, count down the latency, then present and hold the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      work         <= '0;
      o_resp_valid <= 1'b0;
      o_resp_type  <= 1'b0;
      o_resp_addr  <= '0;
      o_resp_data  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (count != '0) begin
            work  <= fifo[rd_ptr];
            cnt   <= CNT_W'(LATENCY - 1);
            state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state        <= S_RESP;
            o_resp_valid <= 1'b1;
            o_resp_type  <= work.typ;
            o_resp_addr  <= {work.idx, {OFF_W{1'b0}}};
            // Writes echo their data; reads see every earlier write because
            // service is strictly one request at a time.
            o_resp_data  <= work.typ ? work.data : mem[work.idx];
          end
        end
        S_RESP: begin
          if (i_resp_ack) begin
            o_resp_valid <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_line_responder.sv
// Scoreboard bench for mem_line_responder: stimulus pushes hand-computed
// expected responses; a monitor pops and compares each new response.
module tb_mem_line_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_mem_enable;
  logic        i_mem_type;
  logic [7:0]  i_mem_addr;
  logic [63:0] i_mem_data;
  logic        o_full;
  logic        o_busy;
  logic        o_resp_valid;
  logic        o_resp_type;
  logic [7:0]  o_resp_addr;
  logic [63:0] o_resp_data;
  logic        i_resp_ack;
  logic        o_overflow;

  typedef struct packed {
    logic        t;
    logic [7:0]  a;
    logic [63:0] d;
  } resp_t;

  resp_t exp_q[$];
  int    n_cmp  = 0;
  int    n_err  = 0;
  int    n_resp = 0;
  logic  prev_valid = 1'b0;

  localparam logic [63:0] D_A = 64'hFF00FF00_00FF00FF;
  localparam logic [63:0] D_B = 64'hDEADBEEF_CAFEBABE;
  localparam logic [63:0] D_C = 64'h12345678_9ABCDEF0;

  mem_line_responder dut (
    .clk          (clk),
    .rst          (rst),
    .i_mem_enable (i_mem_enable),
    .i_mem_type   (i_mem_type),
    .i_mem_addr   (i_mem_addr),
    .i_mem_data   (i_mem_data),
    .o_full       (o_full),
    .o_busy       (o_busy),
    .o_resp_valid (o_resp_valid),
    .o_resp_type  (o_resp_type),
    .o_resp_addr  (o_resp_addr),
    .o_resp_data  (o_resp_data),
    .i_resp_ack   (i_resp_ack),
    .o_overflow   (o_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Monitor: every new response is matched against the head of the scoreboard.
  always @(negedge clk) begin
    if (o_resp_valid && !prev_valid) begin
      n_resp++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected: got %0h, want no response",
                 {o_resp_type, o_resp_addr, o_resp_data});
      end else begin
        check("sb_resp", {o_resp_type, o_resp_addr, o_resp_data}, exp_q.pop_front());
      end
    end
    prev_valid = o_resp_valid;
  end

  // Drive one request for one cycle (from a negedge); optionally expect a response.
  task automatic send(input logic t, input logic [7:0] a, input logic [63:0] d,
                      input logic [63:0] exp_d, input bit expect_resp);
    i_mem_enable = 1'b1;
    i_mem_type   = t;
    i_mem_addr   = a;
    i_mem_data   = d;
    if (expect_resp) exp_q.push_back('{t: t, a: {a[7:3], 3'b000}, d: exp_d});
    @(negedge clk);
    i_mem_enable = 1'b0;
  endtask

  task automatic wait_valid();
    int k = 0;
    while (!o_resp_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!o_resp_valid) begin
      n_cmp++;
      n_err++;
      $display("FAIL resp_timeout: got valid=0, want valid=1 within 100 cycles");
    end
  endtask

  task automatic wait_ack();
    wait_valid();
    i_resp_ack = 1'b1;
    @(negedge clk);
    i_resp_ack = 1'b0;
  endtask

  initial begin
    int base;
    rst = 1'b1;
    i_mem_enable = 1'b0;
    i_mem_type = 1'b0;
    i_mem_addr = '0;
    i_mem_data = '0;
    i_resp_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {o_full, o_busy, o_resp_valid, o_resp_type, o_resp_addr, o_resp_data, o_overflow}, '0);
    rst = 1'b0;

    // Read of an untouched line: latency LATENCY+1, ack drops valid next cycle.
    send(1'b0, 8'hA0, '0, 64'h0, 1'b1);
    repeat (4) @(negedge clk);
    check("latency_not_yet", o_resp_valid, 1'b0);
    @(negedge clk);
    check("latency_valid", o_resp_valid, 1'b1);
    i_resp_ack = 1'b1;
    @(negedge clk);
    i_resp_ack = 1'b0;
    check("ack_drops_valid", o_resp_valid, 1'b0);

    // Write-back then read through a non-aligned address of the same line.
    send(1'b1, 8'hA0, D_A, D_A, 1'b1);
    wait_ack();
    send(1'b0, 8'hA4, '0, D_A, 1'b1);
    wait_ack();

    // Write and read queued back to back: in-order service.
    send(1'b1, 8'hB0, D_B, D_B, 1'b1);
    send(1'b0, 8'hB0, '0, D_B, 1'b1);
    wait_ack();
    check("busy_between_acks", o_busy, 1'b1);
    wait_ack();
    check("idle_after_last_ack", o_busy, 1'b0);

    // Fill the FIFO with ack held low; the fourth request is rejected.
    base = n_resp;
    send(1'b0, 8'h10, '0, 64'h0, 1'b1);
    send(1'b0, 8'h20, '0, 64'h0, 1'b1);
    check("not_full_one_queued", o_full, 1'b0);
    send(1'b0, 8'h30, '0, 64'h0, 1'b1);
    check("full_two_queued", o_full, 1'b1);
    send(1'b0, 8'h40, '0, 64'h0, 1'b0);
    check("overflow_set", o_overflow, 1'b1);
    repeat (3) wait_ack();
    repeat (10) @(negedge clk);
    check("three_responses", n_resp - base, 3);
    check("overflow_sticky", o_overflow, 1'b1);

    // Held response must stay stable while ack is low.
    send(1'b0, 8'hA0, '0, D_A, 1'b1);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_stable", {o_resp_valid, o_resp_type, o_resp_addr, o_resp_data},
            {1'b1, 1'b0, 8'hA0, D_A});
    end
    i_resp_ack = 1'b1;
    @(negedge clk);
    i_resp_ack = 1'b0;
    repeat (2) @(negedge clk);
    i_resp_ack = 1'b1;
    @(negedge clk);
    i_resp_ack = 1'b0;
    @(negedge clk);
    check("idle_ack_ignored", {o_resp_valid, o_busy, o_full, o_resp_type, o_resp_addr, o_resp_data},
          {1'b0, 1'b0, 1'b0, 1'b0, 8'hA0, D_A});

    // Reset while a write is in service discards it.
    send(1'b1, 8'hC0, D_C, D_C, 1'b0);
    repeat (2) @(negedge clk);
    check("busy_before_reset", o_busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_reset_outputs",
          {o_full, o_busy, o_resp_valid, o_resp_type, o_resp_addr, o_resp_data, o_overflow}, '0);
    rst = 1'b0;
    send(1'b0, 8'hC0, '0, 64'h0, 1'b1);
    wait_ack();
    check("overflow_after_reset", o_overflow, 1'b0);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
